// File: rtl/tank_pkg.sv
// Shared types and constants for the tank sprite fetchers (heading enum, screen and sprite sizes).
// Also holds the overflow-safe span test used for sprite bounding boxes.
package tank_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } tank_dir_t;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int COORD_W    = 10;
    localparam int SPR_W_DEF  = 32;
    localparam int SPR_H_DEF  = 32;
    localparam int ADDR_W_DEF = 10;

    // One extra bit keeps start+size from wrapping, so a box hanging off the
    // right/bottom edge is clipped instead of aliasing onto column/row 0.
    function automatic logic span_hit(input logic [COORD_W-1:0] pos,
                                      input logic [COORD_W-1:0] start,
                                      input int                 size);
        logic [COORD_W:0] p;
        logic [COORD_W:0] s;
        logic [COORD_W:0] e;
        p = {1'b0, pos};
        s = {1'b0, start};
        e = s + (COORD_W+1)'(size);
        return (p >= s) && (p < e);
    endfunction

endpackage

// File: rtl/tank_sprite_fetch_if.sv
// Pixel-side bundle of the tank sprite fetcher: scan position, tank state, ROM port and palette output.
// master = video/game side, slave = the fetcher.
interface tank_sprite_fetch_if #(
    parameter int ADDR_W = tank_pkg::ADDR_W_DEF
);
    import tank_pkg::*;

    logic [COORD_W-1:0] DrawX;
    logic [COORD_W-1:0] DrawY;
    logic               blank;
    logic               frame_start;
    logic [COORD_W-1:0] tank_x;
    logic [COORD_W-1:0] tank_y;
    tank_dir_t          tank_dir;
    logic               hit_flash;
    logic [ADDR_W-1:0]  rom_addr;
    logic [3:0]         rom_q;
    logic [3:0]         pal_index;
    logic               sprite_on;

    modport master (
        output DrawX, DrawY, blank, frame_start, tank_x, tank_y, tank_dir, hit_flash, rom_q,
        input  rom_addr, pal_index, sprite_on
    );

    modport slave (
        input  DrawX, DrawY, blank, frame_start, tank_x, tank_y, tank_dir, hit_flash, rom_q,
        output rom_addr, pal_index, sprite_on
    );

endinterface

// File: rtl/tank_sprite_addr.sv
// Combinational sprite-ROM address: rotates local (lx,ly) by heading, addr = srcy*SPR_W + srcx.
// Sprite must be square for the 90-degree cases to stay inside the image.
module tank_sprite_addr
    import tank_pkg::*;
#(
    parameter int SPR_W  = SPR_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LW     = $clog2(SPR_W)
) (
    input  logic [LW-1:0]     lx_i,
    input  logic [LW-1:0]     ly_i,
    input  tank_dir_t         dir_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam logic [LW-1:0] N = LW'(SPR_W - 1);

    logic [LW-1:0] src_x;
    logic [LW-1:0] src_y;

    always_comb begin
        src_x = lx_i;
        src_y = ly_i;
        unique case (dir_i)
            DIR_UP: begin
                src_x = lx_i;
                src_y = ly_i;
            end
            DIR_RIGHT: begin
                src_x = ly_i;
                src_y = N - lx_i;
            end
            DIR_DOWN: begin
                src_x = N - lx_i;
                src_y = N - ly_i;
            end
            DIR_LEFT: begin
                src_x = N - ly_i;
                src_y = lx_i;
            end
            default: begin
                src_x = lx_i;
                src_y = ly_i;
            end
        endcase
        addr_o = ADDR_W'(int'(src_y) * SPR_W + int'(src_x));
    end

endmodule

// File: rtl/tank_sprite_fetch.sv
// Tank sprite fetch: frame-latched position/heading, box test, rotated ROM fetch, transparency and hit-blink.
// DrawX/DrawY sampled on one edge appear as pal_index/sprite_on two edges later (ROM is one-cycle sync).
module tank_sprite_fetch
    import tank_pkg::*;
#(
    parameter int         SPR_W           = SPR_W_DEF,
    parameter int         SPR_H           = SPR_H_DEF,
    parameter int         ADDR_W          = ADDR_W_DEF,
    parameter logic [3:0] TRANSPARENT_IDX = 4'd0,
    parameter int         FLASH_FRAMES    = 30,
    parameter int         BLINK_SHIFT     = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    tank_sprite_fetch_if.slave   bus
);

    localparam int LW    = $clog2(SPR_W);
    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    logic [COORD_W-1:0] sx_q, sx_d;
    logic [COORD_W-1:0] sy_q, sy_d;
    tank_dir_t          sdir_q, sdir_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               v1_q, v1_d;
    logic               v2_q, v2_d;
    logic [3:0]         pal_q, pal_d;
    logic               on_q, on_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               in_box;
    logic               blink_off;
    logic [LW-1:0]      lx;
    logic [LW-1:0]      ly;
    logic [ADDR_W-1:0]  rot_addr;

    always_comb begin
        in_box = span_hit(bus.DrawX, sx_q, SPR_W) && span_hit(bus.DrawY, sy_q, SPR_H);
        lx     = LW'(bus.DrawX - sx_q);
        ly     = LW'(bus.DrawY - sy_q);
    end

    tank_sprite_addr #(
        .SPR_W  (SPR_W),
        .ADDR_W (ADDR_W),
        .LW     (LW)
    ) u_addr (
        .lx_i   (lx),
        .ly_i   (ly),
        .dir_i  (sdir_q),
        .addr_o (rot_addr)
    );

    assign blink_off = (cnt_q != '0) && cnt_q[BLINK_SHIFT];

    always_comb begin
        sx_d       = sx_q;
        sy_d       = sy_q;
        sdir_d     = sdir_q;
        rom_addr_d = rom_addr_q;
        cnt_d      = cnt_q;

        // Shadows only move at frame start so a frame is never torn mid-scan.
        if (bus.frame_start) begin
            sx_d   = bus.tank_x;
            sy_d   = bus.tank_y;
            sdir_d = bus.tank_dir;
        end

        if (in_box) begin
            rom_addr_d = rot_addr;
        end

        v1_d  = in_box & bus.blank;
        v2_d  = v1_q;
        pal_d = bus.rom_q;
        on_d  = v2_q && (bus.rom_q != TRANSPARENT_IDX) && !blink_off;

        // A hit always restarts the blink, even on a frame-start cycle.
        if (bus.hit_flash) begin
            cnt_d = CNT_W'(FLASH_FRAMES);
        end else if (bus.frame_start && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sx_q       <= '0;
            sy_q       <= '0;
            sdir_q     <= DIR_UP;
            rom_addr_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            pal_q      <= '0;
            on_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            sdir_q     <= sdir_d;
            rom_addr_q <= rom_addr_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            pal_q      <= pal_d;
            on_q       <= on_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.pal_index = pal_q;
    assign bus.sprite_on = on_q;

endmodule
